// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit.
// Computes one bit per cycle on operand magnitudes and fixes the sign of the result at the end.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);
    localparam int unsigned      CW      = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
    state_e state_q, state_d;

    logic [2:0]       op_q;
    logic             neg_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, b_q, result_q;

    logic             a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf, early, accept;
    logic [WIDTH-1:0] a_mag, b_mag, early_res;

    always_comb begin
        a_signed  = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg     = a_signed && rs1_data[WIDTH-1];
        b_neg     = b_signed && rs2_data[WIDTH-1];
        a_mag     = a_neg ? -rs1_data : rs1_data;
        b_mag     = b_neg ? -rs2_data : rs2_data;
        div_zero  = funct3[2] && (rs2_data == '0);
        div_ovf   = funct3[2] && !funct3[0] && (rs1_data == MIN_NEG) && (rs2_data == '1);
        early     = div_zero || div_ovf;
        if (div_zero) begin
            early_res = funct3[1] ? rs1_data : '1;
        end else begin
            early_res = funct3[1] ? '0 : rs1_data;
        end
        accept    = (state_q == IDLE) && in_valid && !flush;
    end

    // hi/lo hold {product high, multiplier/product low} or {remainder, dividend/quotient}
    logic [WIDTH:0]     mul_sum, div_sh;
    logic               div_geq;
    logic [WIDTH-1:0]   div_sub, hi_n, lo_n, quot, rem, final_res;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_sh  = {hi_q, lo_q[WIDTH-1]};
        div_geq = (div_sh >= {1'b0, b_q});
        div_sub = div_sh[WIDTH-1:0] - b_q;
        if (op_q[2]) begin
            hi_n = div_geq ? div_sub : div_sh[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], div_geq};
        end else begin
            hi_n = mul_sum[WIDTH:1];
            lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        prod = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
        quot = neg_q ? -lo_n : lo_n;
        rem  = neg_q ? -hi_n : hi_n;
        case (op_q)
            3'b000:                 final_res = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         final_res = quot;
            default:                final_res = rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = early ? DONE : CALC;
            CALC:    if (cnt_q == LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        result    = result_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q  <= funct3;
            neg_q <= (funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= a_mag;
            b_q   <= b_mag;
            if (early) begin
                result_q <= early_res;
            end
        end else if (state_q == CALC) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                result_q <= final_res;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model plus per-cycle handshake/result compare,
// directed vectors with literal results and latencies, flush and reset-abort scenarios.
module tb_muldiv_unit;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic [2:0]    funct3 = '0;
    logic [W-1:0]  rs1 = '0;
    logic [W-1:0]  rs2 = '0;
    logic          in_ready, out_valid, busy;
    logic [W-1:0]  result;

    int n_checks = 0;
    int n_fail = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .rs1_data(rs1), .rs2_data(rs2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, ps;
        longint unsigned ua, ub, pu;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ps  = 0;
        pu  = 0;
        case (f)
            3'd0: pu = ua * ub;
            3'd1: ps = sa * sb;
            3'd2: ps = sa * longint'(ub);
            3'd3: pu = ua * ub;
            3'd4: ps = (b == 0) ? -1 : (ovf ? sa : sa / sb);
            3'd5: pu = (b == 0) ? 64'hFFFF_FFFF : ua / ub;
            3'd6: ps = (b == 0) ? sa : (ovf ? 0 : sa % sb);
            default: pu = (b == 0) ? ua : ua % ub;
        endcase
        case (f)
            3'd0, 3'd5, 3'd7: return pu[31:0];
            3'd3:             return pu[63:32];
            3'd1, 3'd2:       return ps[63:32];
            default:          return ps[31:0];
        endcase
    endfunction

    function automatic bit fast_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Transaction-level model: pending result, cycles still to wait, expected value
    logic         m_pend;
    int           m_wait;
    logic [31:0]  m_exp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 1'b0;
            m_wait <= 0;
            m_exp  <= '0;
        end else if (flush) begin
            m_pend <= 1'b0;
        end else if (m_pend && m_wait > 0) begin
            m_wait <= m_wait - 1;
        end else if (m_pend && out_ready) begin
            m_pend <= 1'b0;
        end else if (!m_pend && in_valid) begin
            m_pend <= 1'b1;
            m_exp  <= ref_op(funct3, rs1, rs2);
            m_wait <= fast_op(funct3, rs1, rs2) ? 0 : W;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", {63'h0, in_ready}, {63'h0, !m_pend});
            check("out_valid", {63'h0, out_valid}, {63'h0, m_pend && m_wait == 0});
            check("busy", {63'h0, busy}, {63'h0, m_pend});
            check("result_known", {63'h0, $isunknown(result)}, 64'h0);
            if (m_pend && m_wait == 0) begin
                check("result", {32'h0, result}, {32'h0, m_exp});
            end
        end
    end

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit, input int lit_lat, input int hold, input string name);
        int cnt;
        funct3 = f; rs1 = a; rs2 = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({name, " latency"}, 64'((cnt == 0) ? 1 : cnt), 64'(lit_lat));
        check({name, " result"}, {32'h0, result}, {32'h0, lit});
        repeat (hold) begin
            @(posedge clk); #1;
        end
        if (hold > 0) check({name, " held"}, {32'h0, result}, {32'h0, lit});
        funct3 = f; rs1 = a; rs2 = b; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check({name, " no accept on handshake"}, {62'h0, out_valid, in_ready}, 64'h1);
    endtask

    initial begin
        #1;
        check("reset in_ready", {63'h0, in_ready}, 64'h1);
        check("reset out_valid", {63'h0, out_valid}, 64'h0);
        check("reset busy", {63'h0, busy}, 64'h0);
        check("reset result", {32'h0, result}, 64'h0);

        check("model MUL", {32'h0, ref_op(3'd0, 32'd7, 32'hFFFF_FFFD)}, 64'hFFFF_FFEB);
        check("model MULH", {32'h0, ref_op(3'd1, 32'h8000_0000, 32'h8000_0000)}, 64'h4000_0000);
        check("model MULHSU", {32'h0, ref_op(3'd2, 32'hFFFF_FFFF, 32'd2)}, 64'hFFFF_FFFF);
        check("model REM", {32'h0, ref_op(3'd6, 32'hFFFF_FFF9, 32'd2)}, 64'hFFFF_FFFF);

        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 32, 0, "MUL 7*-3");
        run_op(3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32, 0, "MULH min*min");
        run_op(3'b011, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32, 0, "MULHU");
        run_op(3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 32, 0, "MULHSU -1*2");
        run_op(3'b101, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF, 1,  0, "DIVU by 0");
        run_op(3'b111, 32'h1234_5678,  32'd0,         32'h1234_5678, 1,  0, "REMU by 0");
        run_op(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  0, "DIV ovf");
        run_op(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1,  0, "REM ovf");
        run_op(3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32, 0, "REM -7%2");
        run_op(3'b101, 32'd100,        32'd7,         32'd14,        32, 5, "DIVU 100/7");
        run_op(3'b100, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 32, 0, "DIV -100/7");
        run_op(3'b110, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, 32, 0, "REM -100%7");
        run_op(3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32, 0, "DIV 7/-2");
        run_op(3'b101, 32'hFFFF_FFFF,  32'd3,         32'h5555_5555, 32, 0, "DIVU big");
        run_op(3'b111, 32'hFFFF_FFFF,  32'h10,        32'hF,         32, 0, "REMU big");
        run_op(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32, 0, "MULHU max");
        run_op(3'b000, 32'h1234_5678,  32'h10,        32'h2345_6780, 32, 0, "MUL shift");
        run_op(3'b100, 32'h8000_0000,  32'd0,         32'hFFFF_FFFF, 1,  0, "DIV min by 0");

        // flush at cycle 10 of CALC
        funct3 = 3'b000; rs1 = 32'd9; rs2 = 32'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush calc out_valid", {63'h0, out_valid}, 64'h0);
        check("flush calc in_ready", {63'h0, in_ready}, 64'h1);
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush beats accept", {63'h0, in_ready}, 64'h1);
        repeat (40) @(posedge clk);
        #1;

        // flush while a result is waiting
        funct3 = 3'b101; rs1 = 32'd5; rs2 = 32'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("done before flush", {63'h0, out_valid}, 64'h1);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        check("flush done out_valid", {63'h0, out_valid}, 64'h0);
        run_op(3'b110, 32'd23, 32'd5, 32'd3, 32, 0, "REM after flush");

        // asynchronous reset mid-CALC
        funct3 = 3'b001; rs1 = 32'd3; rs2 = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("async reset in_ready", {63'h0, in_ready}, 64'h1);
        check("async reset out_valid", {63'h0, out_valid}, 64'h0);
        check("async reset busy", {63'h0, busy}, 64'h0);
        check("async reset result", {32'h0, result}, 64'h0);
        #3 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        run_op(3'b100, 32'd100, 32'd7, 32'd14, 32, 0, "DIV after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
